// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: wb_sel sources, load funct3
// codes, FSM state type and the load-misalignment rule.
// Imported by wb_stage and load_align.
package wb_pkg;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    // Load funct3 encodings; any other value behaves as LW
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // Byte loads are never misaligned; halfwords need an even offset;
    // words (including unlisted encodings) need offset 0.
    function automatic logic load_misaligned(input logic [2:0] load_type,
                                             input logic [1:0] offset);
        logic mis;
        case (load_type)
            LD_LB, LD_LBU: mis = 1'b0;
            LD_LH, LD_LHU: mis = offset[0];
            default:       mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: selects the addressed byte/halfword of a loaded word and
// sign- or zero-extends it to 32 bits. Purely combinational (latency 0).
// Ports: word_i (read word), offset_i (byte offset), load_type_i (funct3), data_o.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        // Halfword choice ignores offset[0]; odd offsets are flagged upstream.
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (load_type_i)
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {24'h000000, byte_sel};
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {16'h0000, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage. Non-load results reach the register
// file port one cycle after the handshake; loads wait in WAIT_MEM for the
// memory read data, then write one cycle after dmem_rvalid_in.
// Backpressure: ready_out is low while a load is outstanding (no timeout).
// Ports: valid_in/ready_out handshake, instruction fields, dmem read return,
// register-file write port (wr_en/rd_addr/rd_data), misaligned flag, retire count.
module wb_stage
    import wb_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        reg_wr_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [1:0]  wb_sel_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] imm_in,
    input  logic [2:0]  load_type_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_data_out,
    output logic        misaligned_out,
    output logic [31:0] retired_cnt_out
);

    wb_state_e   state_q, state_d;

    // Fields of the outstanding load
    logic [4:0]  ld_rd_q,     ld_rd_d;
    logic        ld_wr_q,     ld_wr_d;
    logic [2:0]  ld_type_q,   ld_type_d;
    logic [1:0]  ld_off_q,    ld_off_d;

    // Registered outputs
    logic        wr_en_q,     wr_en_d;
    logic [4:0]  rd_addr_q,   rd_addr_d;
    logic [31:0] rd_data_q,   rd_data_d;
    logic        mis_q,       mis_d;
    logic [31:0] retired_q,   retired_d;

    logic [31:0] direct_data;
    logic [31:0] load_data;
    logic        ld_mis;

    load_align u_load_align (
        .word_i      (dmem_rdata_in),
        .offset_i    (ld_off_q),
        .load_type_i (ld_type_q),
        .data_o      (load_data)
    );

    always_comb begin
        case (wb_sel_in)
            WB_SEL_PC4: direct_data = pc_plus4_in;
            WB_SEL_IMM: direct_data = imm_in;
            default:    direct_data = alu_result_in;
        endcase
    end

    assign ld_mis = load_misaligned(ld_type_q, ld_off_q);

    always_comb begin
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_wr_d   = ld_wr_q;
        ld_type_d = ld_type_q;
        ld_off_d  = ld_off_q;
        wr_en_d   = 1'b0;
        mis_d     = 1'b0;
        rd_addr_d = rd_addr_q;   // address/data hold outside write cycles
        rd_data_d = rd_data_q;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE: begin
                // dmem_rvalid_in is deliberately not looked at here.
                if (valid_in) begin
                    if (wb_sel_in == WB_SEL_LOAD) begin
                        state_d   = ST_WAIT_MEM;
                        ld_rd_d   = rd_addr_in;
                        ld_wr_d   = reg_wr_in;
                        ld_type_d = load_type_in;
                        ld_off_d  = alu_result_in[1:0];
                    end else begin
                        retired_d = retired_q + 32'd1;
                        if (reg_wr_in && (rd_addr_in != 5'd0)) begin
                            wr_en_d   = 1'b1;
                            rd_addr_d = rd_addr_in;
                            rd_data_d = direct_data;
                        end
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (dmem_rvalid_in) begin
                    state_d   = ST_IDLE;
                    retired_d = retired_q + 32'd1;
                    mis_d     = ld_mis;
                    if (!ld_mis && ld_wr_q && (ld_rd_q != 5'd0)) begin
                        wr_en_d   = 1'b1;
                        rd_addr_d = ld_rd_q;
                        rd_data_d = load_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            ld_rd_q   <= 5'd0;
            ld_wr_q   <= 1'b0;
            ld_type_q <= 3'd0;
            ld_off_q  <= 2'd0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            mis_q     <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            ld_rd_q   <= ld_rd_d;
            ld_wr_q   <= ld_wr_d;
            ld_type_q <= ld_type_d;
            ld_off_q  <= ld_off_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            mis_q     <= mis_d;
            retired_q <= retired_d;
        end
    end

    assign ready_out       = (state_q == ST_IDLE);
    assign wr_en_out       = wr_en_q;
    assign rd_addr_out     = rd_addr_q;
    assign rd_data_out     = rd_data_q;
    assign misaligned_out  = mis_q;
    assign retired_cnt_out = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vectors, a transaction-level reference
// model checked every cycle, and hand-computed literal expectations.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        regwr_i = 1'b0;
    logic [4:0]  rd_i = 5'd0;
    logic [1:0]  sel_i = 2'd0;
    logic [31:0] alu_i = 32'd0;
    logic [31:0] pc_i = 32'd0;
    logic [31:0] imm_i = 32'd0;
    logic [2:0]  lt_i = 3'd0;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = 32'd0;
    logic        wr_o;
    logic [4:0]  addr_o;
    logic [31:0] data_o;
    logic        mis_o;
    logic [31:0] cnt_o;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .valid_in        (valid_i),
        .ready_out       (ready_o),
        .reg_wr_in       (regwr_i),
        .rd_addr_in      (rd_i),
        .wb_sel_in       (sel_i),
        .alu_result_in   (alu_i),
        .pc_plus4_in     (pc_i),
        .imm_in          (imm_i),
        .load_type_in    (lt_i),
        .dmem_rvalid_in  (rvalid_i),
        .dmem_rdata_in   (rdata_i),
        .wr_en_out       (wr_o),
        .rd_addr_out     (addr_o),
        .rd_data_out     (data_o),
        .misaligned_out  (mis_o),
        .retired_cnt_out (cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] lt);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (lt)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] lt, input logic [1:0] off);
        if (lt == 3'b000 || lt == 3'b100) return 1'b0;
        if (lt == 3'b001 || lt == 3'b101) return off[0];
        return off != 2'b00;
    endfunction

    bit          m_busy;
    logic [4:0]  p_rd;
    logic        p_wr;
    logic [2:0]  p_lt;
    logic [1:0]  p_off;
    logic        e_wr, e_mis;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; e_wr = 0; e_mis = 0; e_addr = 0; e_data = 0; e_cnt = 0;
            p_rd = 0; p_wr = 0; p_lt = 0; p_off = 0;
        end else begin
            e_wr = 0;
            e_mis = 0;
            if (!m_busy) begin
                if (valid_i) begin
                    if (sel_i == 2'b01) begin
                        m_busy = 1; p_rd = rd_i; p_wr = regwr_i; p_lt = lt_i; p_off = alu_i[1:0];
                    end else begin
                        e_cnt = e_cnt + 1;
                        if (regwr_i && rd_i != 0) begin
                            e_wr = 1;
                            e_addr = rd_i;
                            e_data = (sel_i == 2'b10) ? pc_i : (sel_i == 2'b11) ? imm_i : alu_i;
                        end
                    end
                end
            end else if (rvalid_i) begin
                m_busy = 0;
                e_cnt = e_cnt + 1;
                e_mis = ref_mis(p_lt, p_off);
                if (!e_mis && p_wr && p_rd != 0) begin
                    e_wr = 1;
                    e_addr = p_rd;
                    e_data = ref_load(rdata_i, p_off, p_lt);
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_ready", {31'd0, ready_o}, {31'd0, !m_busy});
            chk("cyc_wr_en", {31'd0, wr_o}, {31'd0, e_wr});
            chk("cyc_mis", {31'd0, mis_o}, {31'd0, e_mis});
            chk("cyc_rd_addr", {27'd0, addr_o}, {27'd0, e_addr});
            chk("cyc_rd_data", data_o, e_data);
            chk("cyc_retired", cnt_o, e_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one cycle of inputs, then return at the following negedge.
    task automatic cyc(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [2:0] lt,
                       input logic rv, input logic [31:0] rdat);
        valid_i = v; regwr_i = rw; rd_i = rd; sel_i = sel; alu_i = alu; lt_i = lt;
        rvalid_i = rv; rdata_i = rdat;
        @(negedge clk);
    endtask

    task automatic alu_op(input logic rw, input logic [4:0] rd, input logic [31:0] a);
        cyc(1, rw, rd, 2'b00, a, 3'd0, 0, 32'd0);
    endtask

    task automatic load_op(input logic [4:0] rd, input logic [2:0] lt, input logic [1:0] off);
        cyc(1, 1, rd, 2'b01, {30'h0400, off}, lt, 0, 32'd0);
    endtask

    task automatic idle();
        cyc(0, 0, 5'd0, 2'b00, 32'd0, 3'd0, 0, 32'd0);
    endtask

    task automatic mem(input logic [31:0] d);
        cyc(0, 0, 5'd0, 2'b00, 32'd0, 3'd0, 1, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        pc_i  = 32'h0000_2004;
        imm_i = 32'hABCD_E000;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_wr_en", {31'd0, wr_o}, 32'd0);
        chk("rst_retired", cnt_o, 32'd0);
        chk("rst_rd_data", data_o, 32'd0);
        rst_n = 1'b1;

        // ALU op right after release
        alu_op(1, 5'd5, 32'h0000_1234);
        chk("alu_wr_en", {31'd0, wr_o}, 32'd1);
        chk("alu_rd_addr", {27'd0, addr_o}, 32'd5);
        chk("alu_rd_data", data_o, 32'h0000_1234);
        chk("alu_retired", cnt_o, 32'd1);

        // LB offset 3, with a stray rvalid during the handshake that must be ignored
        cyc(1, 1, 5'd7, 2'b01, 32'h0000_0103, 3'b000, 1, 32'h1111_1111);
        chk("lb_ready_w1", {31'd0, ready_o}, 32'd0);
        idle();
        chk("lb_ready_w2", {31'd0, ready_o}, 32'd0);
        mem(32'h80AB_CDEF);
        chk("lb_data", data_o, 32'hFFFF_FF80);
        chk("lb_wr_en", {31'd0, wr_o}, 32'd1);
        chk("lb_ready_after", {31'd0, ready_o}, 32'd1);

        // LHU offset 2
        load_op(5'd8, 3'b101, 2'd2);
        mem(32'h8001_7FFF);
        chk("lhu_data", data_o, 32'h0000_8001);

        // LW offset 2: misaligned pulse, no write, still retires
        load_op(5'd9, 3'b010, 2'd2);
        idle();
        mem(32'h1234_5678);
        chk("lw_mis", {31'd0, mis_o}, 32'd1);
        chk("lw_mis_wr_en", {31'd0, wr_o}, 32'd0);
        chk("lw_mis_retired", cnt_o, 32'd4);
        idle();
        chk("lw_mis_pulse_end", {31'd0, mis_o}, 32'd0);

        // More alignment patterns, checked by the model
        load_op(5'd10, 3'b001, 2'd0); mem(32'h8001_7FFF);
        load_op(5'd11, 3'b001, 2'd2); mem(32'h8001_7FFF);
        chk("lh_hi_data", data_o, 32'hFFFF_8001);
        load_op(5'd12, 3'b100, 2'd1); mem(32'h80AB_CDEF);
        chk("lbu_data", data_o, 32'h0000_00CD);
        load_op(5'd13, 3'b000, 2'd1); mem(32'h0000_7F00);
        load_op(5'd14, 3'b111, 2'd0); mem(32'hCAFE_F00D);
        chk("unlisted_lw_data", data_o, 32'hCAFE_F00D);
        load_op(5'd15, 3'b110, 2'd1); mem(32'hCAFE_F00D);
        load_op(5'd16, 3'b001, 2'd1); mem(32'hCAFE_F00D);
        load_op(5'd17, 3'b010, 2'd0); idle(); idle(); mem(32'h0BAD_F00D);

        // rd=0 and reg_wr=0: no write, retire, data holds
        alu_op(1, 5'd0, 32'hDEAD_BEEF);
        chk("rd0_wr_en", {31'd0, wr_o}, 32'd0);
        chk("rd0_hold", data_o, 32'h0BAD_F00D);
        alu_op(0, 5'd3, 32'h5555_5555);
        cyc(1, 1, 5'd20, 2'b10, 32'd0, 3'd0, 0, 32'd0);
        chk("pc4_data", data_o, 32'h0000_2004);
        cyc(1, 1, 5'd21, 2'b11, 32'd0, 3'd0, 0, 32'd0);
        chk("imm_data", data_o, 32'hABCD_E000);
        idle();

        // Four back-to-back ALU ops
        run = 0;
        for (int i = 0; i < 4; i++) begin
            alu_op(1, 5'(i + 1), 32'h100 * (i + 1));
            if (wr_o && data_o == 32'h100 * (i + 1)) run++;
        end
        chk("b2b_run", run, 32'd4);
        idle();
        chk("b2b_end", {31'd0, wr_o}, 32'd0);

        // Counter wrap
        #2;
        dut.retired_q = 32'hFFFF_FFFF;
        e_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        alu_op(1, 5'd6, 32'h0000_0006);
        chk("wrap_retired", cnt_o, 32'd0);

        // Reset while a load is pending
        load_op(5'd22, 3'b010, 2'd0);
        chk("pend_ready", {31'd0, ready_o}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {31'd0, ready_o}, 32'd1);
        chk("async_rst_data", data_o, 32'd0);
        chk("async_rst_retired", cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem(32'h7777_7777);
        chk("post_rst_wr_en", {31'd0, wr_o}, 32'd0);
        chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
        chk("post_rst_retired", cnt_o, 32'd0);
        alu_op(1, 5'd4, 32'h0000_0044);
        chk("post_rst_alu", data_o, 32'h0000_0044);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
